// File: rtl/trace_lane_serializer_if.sv
// trace_lane_serializer_if
// Bundles the multi-lane retire trace input, the record output handshake and
// the overflow/occupancy status of trace_lane_serializer. The master side
// drives trace packets and consumes records; the slave side is the serializer.
// Optional feature macro: RV_TRACE_DROP_CNT_EN adds the drop_cnt status field.

interface trace_lane_serializer_if #(
    parameter int LANES = 3,
    parameter int DEPTH = 8
);
    logic [LANES-1:0]         trace_valid;
    logic [LANES*32-1:0]      trace_insn;
    logic [LANES*32-1:0]      trace_addr;
    logic [LANES-1:0]         trace_exception;
    logic [LANES-1:0]         trace_interrupt;
    logic [4:0]               trace_ecause;
    logic [31:0]              trace_tval;

    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_insn;
    logic [31:0]              out_addr;
    logic                     out_exception;
    logic                     out_interrupt;
    logic [4:0]               out_ecause;
    logic [31:0]              out_tval;

    logic                     ovf;
    logic                     ovf_clr;
    logic [$clog2(DEPTH):0]   count;
`ifdef RV_TRACE_DROP_CNT_EN
    logic [15:0]              drop_cnt;
`endif

    modport master (
        output trace_valid, trace_insn, trace_addr, trace_exception,
               trace_interrupt, trace_ecause, trace_tval, out_ready, ovf_clr,
        input  out_valid, out_insn, out_addr, out_exception, out_interrupt,
               out_ecause, out_tval, ovf, count
`ifdef RV_TRACE_DROP_CNT_EN
        , input drop_cnt
`endif
    );

    modport slave (
        input  trace_valid, trace_insn, trace_addr, trace_exception,
               trace_interrupt, trace_ecause, trace_tval, out_ready, ovf_clr,
        output out_valid, out_insn, out_addr, out_exception, out_interrupt,
               out_ecause, out_tval, ovf, count
`ifdef RV_TRACE_DROP_CNT_EN
        , output drop_cnt
`endif
    );
endinterface

// File: rtl/trace_lane_serializer.sv
// trace_lane_serializer
// Compacts the valid lanes of each retire packet, in program order, into a
// circular buffer and drains one instruction record per cycle over a
// valid/ready handshake. Retirement cannot be stalled, so a packet that does
// not fit in the free space seen at the start of the cycle is dropped whole
// and the sticky ovf flag is raised.
// Optional feature macro: RV_TRACE_DROP_CNT_EN adds a saturating 16-bit
// dropped-packet counter on bus.drop_cnt.

module trace_lane_serializer #(
    parameter int LANES = 3,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_l,
    trace_lane_serializer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exception;
        logic        interrupt;
        logic [4:0]  ecause;
        logic [31:0] tval;
    } rec_t;

    rec_t          r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic          r_ovf;

    logic [PW-1:0] w_n;
    logic [AW-1:0] w_offset [LANES];
    rec_t          w_rec [LANES];
    logic [PW-1:0] w_count;
    logic [PW-1:0] w_free;
    logic          w_fit;
    logic          w_drop;
    logic          w_valid;
    logic          w_pop;
    rec_t          w_head;

    // Running popcount gives each valid lane its slot offset from wr_ptr.
    always_comb begin
        w_n = '0;
        for (int i = 0; i < LANES; i++) begin
            w_offset[i] = w_n[AW-1:0];
            w_n         = w_n + PW'(bus.trace_valid[i]);
        end
    end

    // Build one record per lane; cause and tval only travel with traps.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_rec[i].insn      = bus.trace_insn[32*i +: 32];
            w_rec[i].addr      = bus.trace_addr[32*i +: 32];
            w_rec[i].exception = bus.trace_exception[i];
            w_rec[i].interrupt = bus.trace_interrupt[i];
            if (bus.trace_exception[i] || bus.trace_interrupt[i]) begin
                w_rec[i].ecause = bus.trace_ecause;
                w_rec[i].tval   = bus.trace_tval;
            end else begin
                w_rec[i].ecause = '0;
                w_rec[i].tval   = '0;
            end
        end
    end

    assign w_count = r_wrPtr - r_rdPtr;
    assign w_free  = PW'(DEPTH) - w_count;
    assign w_fit   = (w_n <= w_free);
    assign w_drop  = (w_n != '0) && !w_fit;
    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && bus.out_ready;

    // Storage is deliberately unreset; a whole packet is written or none of it.
    always_ff @(posedge clk) begin
        if (w_fit) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.trace_valid[i]) begin
                    r_mem[r_wrPtr[AW-1:0] + w_offset[i]] <= w_rec[i];
                end
            end
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_fit) begin
                r_wrPtr <= r_wrPtr + w_n;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef RV_TRACE_DROP_CNT_EN
    logic [15:0] r_dropCnt;

    // Saturating dropped-packet count; a clear restarts it at the current drop.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_dropCnt <= '0;
        end else if (bus.ovf_clr) begin
            r_dropCnt <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (r_dropCnt != 16'hFFFF)) begin
            r_dropCnt <= r_dropCnt + 16'd1;
        end
    end

    assign bus.drop_cnt = r_dropCnt;
`endif

    assign w_head = w_valid ? r_mem[r_rdPtr[AW-1:0]] : '0;

    assign bus.out_valid     = w_valid;
    assign bus.out_insn      = w_head.insn;
    assign bus.out_addr      = w_head.addr;
    assign bus.out_exception = w_head.exception;
    assign bus.out_interrupt = w_head.interrupt;
    assign bus.out_ecause    = w_head.ecause;
    assign bus.out_tval      = w_head.tval;
    assign bus.ovf           = r_ovf;
    assign bus.count         = w_count;
endmodule
